// File: rtl/memory_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the single memory slave.
// The slave modport is the arbiter's view; the master modport is the
// environment's view (both masters plus the memory).
interface memory_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  m0_req;
   logic                  m0_we;
   logic [ADDR_WIDTH-1:0] m0_addr;
   logic [DATA_WIDTH-1:0] m0_wdata;
   logic [DATA_WIDTH-1:0] m0_rdata;
   logic                  m0_ack;
   logic                  m0_err;

   logic                  m1_req;
   logic                  m1_we;
   logic [ADDR_WIDTH-1:0] m1_addr;
   logic [DATA_WIDTH-1:0] m1_wdata;
   logic [DATA_WIDTH-1:0] m1_rdata;
   logic                  m1_ack;
   logic                  m1_err;

   logic                  mem_read;
   logic                  mem_write;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_ack;

   logic                  busy;
   logic                  grant;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      output m0_rdata, m0_ack, m0_err,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      output m1_rdata, m1_ack, m1_err,
      output mem_read, mem_write, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack,
      output busy, grant
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      input  m0_rdata, m0_ack, m0_err,
      output m1_req, m1_we, m1_addr, m1_wdata,
      input  m1_rdata, m1_ack, m1_err,
      input  mem_read, mem_write, mem_addr, mem_wdata,
      output mem_rdata, mem_ack,
      input  busy, grant
   );
endinterface

// File: rtl/memory_arbiter.sv
// Two-master round-robin arbiter for the unified memory port.
// One transfer in flight at a time: IDLE arbitrates, BUSY drives the slave
// until mem_ack or watchdog expiry, RESP returns a one-cycle ack to the owner.
module memory_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input logic               clk,
   input logic               reset,
   memory_arbiter_if.slave   bus
);

   // Counter wide enough for TIMEOUT; a single bit suffices when disabled.
   localparam int CNT_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam int LAST_INT = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
   localparam logic [CNT_W-1:0] CNT_LAST = LAST_INT[CNT_W-1:0];

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t            state_reg, state_next;
   logic              owner_reg, owner_next;
   logic              last_grant_reg, last_grant_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic              done_ok, done_tmo;
   logic              pick;

   // Master-side request fields gathered into vectors so the owner can index them.
   logic [1:0]            req_vec;
   logic [1:0]            we_vec;
   logic [ADDR_WIDTH-1:0] addr_vec  [2];
   logic [DATA_WIDTH-1:0] wdata_vec [2];

   assign req_vec      = {bus.m1_req, bus.m0_req};
   assign we_vec       = {bus.m1_we,  bus.m0_we};
   assign addr_vec[0]  = bus.m0_addr;
   assign addr_vec[1]  = bus.m1_addr;
   assign wdata_vec[0] = bus.m0_wdata;
   assign wdata_vec[1] = bus.m1_wdata;

   // On a tie the master that did not win last time gets the bus.
   assign pick = (&req_vec) ? ~last_grant_reg : req_vec[1];

   // Next-state logic: arbitration, slave completion and watchdog.
   always_comb begin
      state_next      = state_reg;
      owner_next      = owner_reg;
      last_grant_next = last_grant_reg;
      cnt_next        = cnt_reg;
      done_ok         = 1'b0;
      done_tmo        = 1'b0;
      case (state_reg)
         IDLE: begin
            if (|req_vec) begin
               owner_next      = pick;
               last_grant_next = pick;
               cnt_next        = '0;
               state_next      = BUSY;
            end
         end
         BUSY: begin
            if (bus.mem_ack) begin
               // A late ack on the expiry cycle still counts as success.
               done_ok    = 1'b1;
               state_next = RESP;
            end else if (TIMEOUT != 0) begin
               if (cnt_reg == CNT_LAST) begin
                  done_tmo   = 1'b1;
                  state_next = RESP;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Arbiter state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         owner_reg      <= 1'b0;
         last_grant_reg <= 1'b1;
         cnt_reg        <= '0;
      end else begin
         state_reg      <= state_next;
         owner_reg      <= owner_next;
         last_grant_reg <= last_grant_next;
         cnt_reg        <= cnt_next;
      end
   end

   // Per-master response registers: ack/err live for the RESP cycle only,
   // rdata holds until that master's next completion.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_master
         logic [DATA_WIDTH-1:0] rdata_reg;
         logic                  ack_reg;
         logic                  err_reg;
         logic                  mine;

         assign mine = (owner_reg == 1'(gi));

         // Capture completion for this master when it owns the transfer.
         always_ff @(posedge clk) begin
            if (reset) begin
               rdata_reg <= '0;
               ack_reg   <= 1'b0;
               err_reg   <= 1'b0;
            end else begin
               ack_reg <= (done_ok | done_tmo) & mine;
               err_reg <= done_tmo & mine;
               if (done_ok && mine) begin
                  rdata_reg <= bus.mem_rdata;
               end else if (done_tmo && mine) begin
                  rdata_reg <= '0;
               end
            end
         end
      end
   endgenerate

   assign bus.m0_rdata = g_master[0].rdata_reg;
   assign bus.m0_ack   = g_master[0].ack_reg;
   assign bus.m0_err   = g_master[0].err_reg;
   assign bus.m1_rdata = g_master[1].rdata_reg;
   assign bus.m1_ack   = g_master[1].ack_reg;
   assign bus.m1_err   = g_master[1].err_reg;

   // Slave side is driven only in BUSY, straight from the owner's fields.
   assign bus.mem_read  = (state_reg == BUSY) & ~we_vec[owner_reg];
   assign bus.mem_write = (state_reg == BUSY) &  we_vec[owner_reg];
   assign bus.mem_addr  = (state_reg == BUSY) ? addr_vec[owner_reg]  : '0;
   assign bus.mem_wdata = (state_reg == BUSY) ? wdata_vec[owner_reg] : '0;

   assign bus.busy  = (state_reg != IDLE);
   assign bus.grant = (state_reg != IDLE) & owner_reg;

endmodule

// File: tb/tb_memory_arbiter.sv
// Scoreboard bench for memory_arbiter (watchdog TIMEOUT = 4).
module tb_memory_arbiter;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   memory_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic          mst;
      logic          chk_rdata;
      logic [DW-1:0] rdata;
      logic          err;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Slave model: acks after slave_waits wait states, or never.
   int            slave_waits     = 0;
   bit            slave_never     = 0;
   bit            slave_addr_mode = 0;
   logic [DW-1:0] slave_data      = '0;
   int            wait_cnt        = 0;
   logic          s_ack           = 1'b0;
   logic [DW-1:0] s_rdata         = '1;

   assign bus.mem_ack   = s_ack;
   assign bus.mem_rdata = s_rdata;

   // Respond shortly after each rising edge so ack lands in the same cycle.
   always @(posedge clk) begin
      #1;
      if (bus.mem_read || bus.mem_write) begin
         s_rdata = slave_addr_mode ? (bus.mem_addr + 32'h1) : slave_data;
         if (!slave_never && wait_cnt >= slave_waits) begin
            s_ack = 1'b1;
         end else begin
            s_ack = 1'b0;
            wait_cnt++;
         end
      end else begin
         s_ack    = 1'b0;
         s_rdata  = '1;
         wait_cnt = 0;
      end
   end

   // Monitor: every ack pops the scoreboard and is checked against it.
   logic prev_ack [2] = '{1'b0, 1'b0};
   always @(negedge clk) begin
      exp_t          e;
      logic          a;
      logic          er;
      logic [DW-1:0] rd;
      for (int m = 0; m < 2; m++) begin
         a  = (m == 0) ? bus.m0_ack   : bus.m1_ack;
         er = (m == 0) ? bus.m0_err   : bus.m1_err;
         rd = (m == 0) ? bus.m0_rdata : bus.m1_rdata;
         if (a) begin
            $display("t=%0t ack m%0d rdata=%h err=%b", $time, m, rd, er);
            n_checks++;
            if (prev_ack[m] !== 1'b0) begin
               n_fail++;
               $display("FAIL ack_pulse m%0d: ack high on consecutive cycles, required single pulse", m);
            end
            n_checks++;
            if (sb_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_ack m%0d: ack seen, required none", m);
            end else begin
               e = sb_q.pop_front();
               n_checks++;
               if (1'(m) !== e.mst) begin
                  n_fail++;
                  $display("FAIL ack_owner: got m%0d, required m%0d", m, e.mst);
               end
               n_checks++;
               if (er !== e.err) begin
                  n_fail++;
                  $display("FAIL ack_err m%0d: got %b, required %b", m, er, e.err);
               end
               if (e.chk_rdata) begin
                  n_checks++;
                  if (rd !== e.rdata) begin
                     n_fail++;
                     $display("FAIL ack_rdata m%0d: got %h, required %h", m, rd, e.rdata);
                  end
               end
            end
         end
         prev_ack[m] = a;
      end
   end

   task automatic drive_req(input int m, input logic req, input logic we,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (m == 0) begin
         bus.m0_req = req; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d;
      end else begin
         bus.m1_req = req; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d;
      end
   endtask

   // Issue one transfer and measure strobe/busy/ack timing (cycle 0 = IDLE).
   task automatic do_xfer(input int m, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, output int ack_cyc,
                          output int rd_cyc, output int wr_cyc, output int busy_cyc,
                          output bit stable_ok);
      logic a;
      ack_cyc = -1; rd_cyc = 0; wr_cyc = 0; busy_cyc = 0; stable_ok = 1'b1;
      @(posedge clk); #1;
      drive_req(m, 1'b1, we, addr, wdata);
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         if (bus.mem_read)  rd_cyc++;
         if (bus.mem_write) wr_cyc++;
         if (bus.busy)      busy_cyc++;
         if ((bus.mem_read || bus.mem_write) &&
             (bus.mem_addr !== addr || (we && bus.mem_wdata !== wdata)))
            stable_ok = 1'b0;
         a = (m == 0) ? bus.m0_ack : bus.m1_ack;
         if (a) begin
            ack_cyc = cyc;
            break;
         end
      end
      drive_req(m, 1'b0, we, addr, wdata);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive_req(0, 1'b0, 1'b0, '0, '0);
      drive_req(1, 1'b0, 1'b0, '0, '0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({bus.mem_read, bus.mem_write, bus.busy, bus.grant,
           bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err} !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b%b%b%b%b%b%b%b, required 00000000",
                  bus.mem_read, bus.mem_write, bus.busy, bus.grant,
                  bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err);
      end
      n_checks++;
      if (bus.m0_rdata !== '0 || bus.m1_rdata !== '0) begin
         n_fail++;
         $display("FAIL reset_rdata: got %h/%h, required 0/0", bus.m0_rdata, bus.m1_rdata);
      end
      n_checks++;
      if (bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
         n_fail++;
         $display("FAIL reset_membus: got %h/%h, required 0/0", bus.mem_addr, bus.mem_wdata);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      $display("t=%0t reset released", $time);
   endtask

   task automatic test_single_read();
      int ac, rc, wc, bc; bit st;
      slave_waits = 0; slave_never = 0; slave_addr_mode = 0; slave_data = 32'hDEADBEEF;
      sb_q.push_back('{mst: 1'b0, chk_rdata: 1'b1, rdata: 32'hDEADBEEF, err: 1'b0});
      do_xfer(0, 1'b0, 32'h100, 32'h0, ac, rc, wc, bc, st);
      n_checks++;
      if (ac !== 2) begin n_fail++; $display("FAIL read_latency: got %0d, required 2", ac); end
      n_checks++;
      if (rc !== 1 || wc !== 0) begin
         n_fail++; $display("FAIL read_strobes: got rd=%0d wr=%0d, required rd=1 wr=0", rc, wc);
      end
      n_checks++;
      if (!st) begin n_fail++; $display("FAIL read_addr: got unstable/wrong addr, required 100"); end
   endtask

   task automatic test_write_wait();
      int ac, rc, wc, bc; bit st;
      slave_waits = 3; slave_never = 0; slave_addr_mode = 0; slave_data = 32'h0BADF00D;
      sb_q.push_back('{mst: 1'b1, chk_rdata: 1'b0, rdata: '0, err: 1'b0});
      do_xfer(1, 1'b1, 32'h40, 32'h12345678, ac, rc, wc, bc, st);
      n_checks++;
      if (wc !== 4 || rc !== 0) begin
         n_fail++; $display("FAIL write_strobes: got wr=%0d rd=%0d, required wr=4 rd=0", wc, rc);
      end
      n_checks++;
      if (bc !== 5) begin n_fail++; $display("FAIL write_busy: got %0d, required 5", bc); end
      n_checks++;
      if (ac !== 5) begin n_fail++; $display("FAIL write_latency: got %0d, required 5", ac); end
      n_checks++;
      if (!st) begin n_fail++; $display("FAIL write_bus: got unstable addr/wdata, required 40/12345678"); end
      n_checks++;
      if (bus.m0_rdata !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL rdata_hold: got %h, required deadbeef", bus.m0_rdata);
      end
   endtask

   task automatic test_timeout();
      int ac, rc, wc, bc; bit st;
      slave_waits = 0; slave_never = 1; slave_addr_mode = 0; slave_data = '1;
      sb_q.push_back('{mst: 1'b0, chk_rdata: 1'b1, rdata: '0, err: 1'b1});
      do_xfer(0, 1'b0, 32'h104, 32'h0, ac, rc, wc, bc, st);
      n_checks++;
      if (rc !== TMO) begin n_fail++; $display("FAIL timeout_busy: got %0d, required %0d", rc, TMO); end
      n_checks++;
      if (ac !== TMO + 1) begin n_fail++; $display("FAIL timeout_ack: got %0d, required %0d", ac, TMO + 1); end
      @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL timeout_idle: got busy=%b, required 0", bus.busy); end
      slave_never = 0;
   endtask

   task automatic test_tie_expiry();
      int ac, rc, wc, bc; bit st;
      slave_waits = TMO - 1; slave_never = 0; slave_addr_mode = 0; slave_data = 32'hA5A5A5A5;
      sb_q.push_back('{mst: 1'b0, chk_rdata: 1'b1, rdata: 32'hA5A5A5A5, err: 1'b0});
      do_xfer(0, 1'b0, 32'h108, 32'h0, ac, rc, wc, bc, st);
      n_checks++;
      if (rc !== TMO || ac !== TMO + 1) begin
         n_fail++; $display("FAIL tie_timing: got rd=%0d ack=%0d, required %0d/%0d", rc, ac, TMO, TMO + 1);
      end
   endtask

   task automatic test_contention();
      int  acks = 0; int issued = 2; bit rearm0 = 1, rearm1 = 1;
      slave_waits = 0; slave_never = 0; slave_addr_mode = 1;
      sb_q.push_back('{mst: 1'b0, chk_rdata: 1'b1, rdata: 32'h201, err: 1'b0});
      sb_q.push_back('{mst: 1'b1, chk_rdata: 1'b1, rdata: 32'h301, err: 1'b0});
      sb_q.push_back('{mst: 1'b0, chk_rdata: 1'b1, rdata: 32'h201, err: 1'b0});
      sb_q.push_back('{mst: 1'b1, chk_rdata: 1'b1, rdata: 32'h301, err: 1'b0});
      for (int cyc = 0; cyc < 80 && acks < 4; cyc++) begin
         @(posedge clk); #1;
         if (rearm0) begin drive_req(0, 1'b1, 1'b0, 32'h200, '0); rearm0 = 0; end
         if (rearm1) begin drive_req(1, 1'b1, 1'b0, 32'h300, '0); rearm1 = 0; end
         @(negedge clk);
         if (bus.m0_ack || bus.m1_ack) begin
            n_checks++;
            if (bus.grant !== 1'(acks % 2)) begin
               n_fail++; $display("FAIL contention_grant #%0d: got %b, required %0d", acks, bus.grant, acks % 2);
            end
            acks++;
            if (bus.m0_ack) begin
               drive_req(0, 1'b0, 1'b0, 32'h200, '0);
               if (issued < 4) begin rearm0 = 1; issued++; end
            end
            if (bus.m1_ack) begin
               drive_req(1, 1'b0, 1'b0, 32'h300, '0);
               if (issued < 4) begin rearm1 = 1; issued++; end
            end
         end
      end
      n_checks++;
      if (acks !== 4) begin n_fail++; $display("FAIL contention_count: got %0d acks, required 4", acks); end
      drive_req(0, 1'b0, 1'b0, '0, '0);
      drive_req(1, 1'b0, 1'b0, '0, '0);
      slave_addr_mode = 0;
   endtask

   task automatic test_reset_mid_busy();
      bit seen = 0; bit first = 1; bit done0 = 0, done1 = 0;
      slave_never = 1; slave_waits = 0;
      @(posedge clk); #1;
      drive_req(1, 1'b1, 1'b0, 32'h80, '0);
      for (int cyc = 0; cyc < 6 && !seen; cyc++) begin
         @(negedge clk);
         if (bus.busy) seen = 1;
      end
      @(negedge clk);
      n_checks++;
      if (bus.mem_read !== 1'b1) begin n_fail++; $display("FAIL midrst_pending: got mem_read=%b, required 1", bus.mem_read); end
      reset = 1'b1;
      drive_req(1, 1'b0, 1'b0, 32'h80, '0);
      @(negedge clk);
      n_checks++;
      if ({bus.mem_read, bus.mem_write, bus.busy, bus.grant,
           bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err} !== 8'h00) begin
         n_fail++; $display("FAIL midrst_ctrl: got busy=%b rd=%b ack1=%b, required all 0",
                            bus.busy, bus.mem_read, bus.m1_ack);
      end
      n_checks++;
      if (bus.m0_rdata !== '0 || bus.m1_rdata !== '0 || bus.mem_addr !== '0) begin
         n_fail++; $display("FAIL midrst_data: got %h/%h/%h, required 0/0/0",
                            bus.m0_rdata, bus.m1_rdata, bus.mem_addr);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      slave_never = 0; slave_addr_mode = 1;
      sb_q.push_back('{mst: 1'b0, chk_rdata: 1'b1, rdata: 32'h501, err: 1'b0});
      sb_q.push_back('{mst: 1'b1, chk_rdata: 1'b1, rdata: 32'h601, err: 1'b0});
      drive_req(0, 1'b1, 1'b0, 32'h500, '0);
      drive_req(1, 1'b1, 1'b0, 32'h600, '0);
      for (int cyc = 0; cyc < 30 && !(done0 && done1); cyc++) begin
         @(negedge clk);
         if (bus.busy && first) begin
            first = 0;
            n_checks++;
            if (bus.grant !== 1'b0) begin n_fail++; $display("FAIL midrst_first_grant: got %b, required 0", bus.grant); end
         end
         if (bus.m0_ack) begin drive_req(0, 1'b0, 1'b0, 32'h500, '0); done0 = 1; end
         if (bus.m1_ack) begin drive_req(1, 1'b0, 1'b0, 32'h600, '0); done1 = 1; end
      end
      n_checks++;
      if (!(done0 && done1)) begin n_fail++; $display("FAIL midrst_dual: got acks %b%b, required 11", done0, done1); end
      slave_addr_mode = 0;
   endtask

   initial begin
      reset = 1'b1;
      drive_req(0, 1'b0, 1'b0, '0, '0);
      drive_req(1, 1'b0, 1'b0, '0, '0);
      test_reset();
      test_single_read();
      test_write_wait();
      test_timeout();
      test_tie_expiry();
      test_reset();
      test_contention();
      test_reset_mid_busy();
      repeat (3) @(negedge clk);
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++; $display("FAIL scoreboard_drain: got %0d pending, required 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
